dcpu16_fbus: RTL
================

Name: dcpu16_fbus

Overview:
Instruction fetch and operand sequencer. Sits directly upstream of the A/B operand bus.
- Fetches instruction words over its own simplified Wishbone port and holds the program counter.
- Drives the ea / pha / ena sequence that makes the operand bus load regA and regB.
- Advances PC past next-word operands, handles conditional skip, and accepts PC writes from execute.

Parameters:
RST_PC  16'h0000  PC value loaded on reset

Ports:
clk     in   1   system clock
rst     in   1   reset; synchronous, active-high
f_adr   out  16  fetch address
f_stb   out  1   fetch strobe
f_ena   out  1   equals f_stb
f_wre   out  1   tied 0 (read-only)
f_dti   in   16  fetch read data
f_ack   in   1   fetch acknowledge
regPC   out  16  program counter (to operand bus)
ir      out  16  current instruction word
ea      out  6   effective-address code to operand bus
pha     out  1   operand phase: 0 = capture into regA, 1 = capture into regB
ena     out  1   operand bus enable
exe     out  1   one-cycle execute strobe to ALU/write-back
pc_wre  in   1   execute writes PC (sampled in EX only)
pc_dti  in   16  new PC value
skp     in   1   IF* condition failed, skip next instruction (sampled in EX only)

Behaviour:
- Instruction format: ir[3:0] = opcode, ir[9:4] = a, ir[15:10] = b. Opcode 0 is non-basic: its single operand is ir[15:10].
- Next-word predicate nw(x): true for x in 6'h10–6'h17, 6'h1e, 6'h1f.
- Operand capture timing: the ea presented with ena=1 in cycle n is captured in cycle n+1 according to pha in cycle n+1.
- Reset values: PC=RST_PC, ir=0, ea=0, pha=0, ena=0, exe=0, f_stb=0, state=FE.
- f_stb first asserts in the cycle after rst deasserts.
- States:
  - FE: f_stb=1, f_adr=PC. On f_ack: ir<=f_dti, PC<=PC+1, go LA.
    - f_stb and f_adr stay stable until f_ack; there is no timeout.
    - f_stb drops in the cycle after the ack.
  - LA: ena=1, pha=1, ea=a (basic) or ir[15:10] (non-basic). PC<=PC+1 if nw(ea).
    - Basic: go LB.
    - Non-basic: go LC; regB is a don't-care for non-basic.
  - LB: ena=1, pha=0 (regA captures the LA operand), ea=b. PC<=PC+1 if nw(b). Go LC.
  - LC: ena=1, pha=1 (regB captures the LB operand), ea=6'h20 (literal, no bus access). Go EX.
    - Non-basic: pha=0 here instead, so regA captures the operand.
  - EX: ena=0, exe=1 for exactly one cycle.
    - pc_wre=1: PC<=pc_dti; go FE.
    - else skp=1: go SK.
    - else: go FE.
    - pc_wre has priority over skp.
  - SK: fetch at PC as in FE; ir is not updated. On f_ack: PC<=PC+1+nw(f_dti[9:4])+nw(f_dti[15:10]); go FE.
    - If f_dti[3:0]==0, only f_dti[15:10] is counted.
    - exe never asserts for a skipped word.
- All PC arithmetic is mod 2^16. 16'hFFFF+1 wraps to 16'h0000, including a next-word fetch at 16'hFFFF.
- Reset asserted in any state, including mid-handshake:
  - Next cycle shows reset values.
  - An f_ack arriving during or right after reset is ignored.
  - No exe pulse is emitted.
- pc_wre or skp outside EX: ignored.
- regPC is the live PC register. In LA/LB it points at the next-word location for the operand being issued.

Test Plan:
- Reset: hold rst 3 cycles mid-FE with f_ack=1 -> regPC=0000, f_stb=0, ena=0, exe=0. f_stb=1 with f_adr=0000 on the cycle after release.
- SET A,0x30 (mem[0]=7c01, mem[1]=0030), zero-wait ack -> LA ea=00 regPC=0001; LB ea=1f regPC=0001, then 0002; exe one cycle; next f_adr=0002.
- Non-basic JSR literal 4 (mem[0]=9010) -> LA ea=24 pha=1; LC pha=0; no LB cycle; exe pulses; regPC=0001. pc_wre=1, pc_dti=0040 in EX -> next f_adr=0040.
- Skip: IFE at 0000 with skp=1 in EX; mem[1]=7c01 -> SK reads 0001, regPC=0003, no exe; next fetch at 0003.
- Wait states: f_ack delayed 4 cycles -> f_stb and f_adr held constant; ir unchanged until ack; state advances exactly one cycle after ack.
- Wrap: RST_PC=FFFF, mem[FFFF]=7c01 -> after LB regPC=0001 (FFFF→0000→0001).

Source files
------------

// File: rtl/dcpu16_fbus.sv
// ---------------------------------------------------------------------------
// dcpu16_fbus
// Instruction fetch and operand sequencer for the DCPU-16 core. It owns the
// program counter, fetches instruction words over a simple read-only
// Wishbone-style port, and then walks the operand bus through the sequence
// that loads regA and regB. At the end it pulses exe for one cycle. A
// conditional skip (IF* failure) is handled by a fetch-only pass that steps
// PC over the skipped word and any next-word operands it carries.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   f_adr/f_stb     fetch address and strobe (f_ena mirrors f_stb)
//   f_wre           always 0, the port is read-only
//   f_dti/f_ack     fetch read data and acknowledge
//   regPC           live program counter, exported to the operand bus
//   ir              currently executing instruction word
//   ea/pha/ena      operand bus effective address, capture phase and enable
//   exe             one-cycle execute strobe
//   pc_wre/pc_dti   PC write from execute (honoured only in EX)
//   skp             skip request from execute (honoured only in EX)
// ---------------------------------------------------------------------------
module dcpu16_fbus #(
  parameter logic [15:0] RST_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] f_adr,
  output logic        f_stb,
  output logic        f_ena,
  output logic        f_wre,
  input  logic [15:0] f_dti,
  input  logic        f_ack,
  output logic [15:0] regPC,
  output logic [15:0] ir,
  output logic [5:0]  ea,
  output logic        pha,
  output logic        ena,
  output logic        exe,
  input  logic        pc_wre,
  input  logic [15:0] pc_dti,
  input  logic        skp
);

  typedef enum logic [2:0] {
    FE = 3'd0,
    LA = 3'd1,
    LB = 3'd2,
    LC = 3'd3,
    EX = 3'd4,
    SK = 3'd5
  } state_t;

  // Operand codes 0x10-0x17, 0x1e and 0x1f consume an extra program word.
  function automatic logic isNextWord(input logic [5:0] x);
    return (x[5:3] == 3'b010) || (x == 6'h1e) || (x == 6'h1f);
  endfunction

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [5:0]  r_ea;
  logic        r_pha;
  logic        r_ena;
  logic        r_exe;
  logic        r_stb;

  logic        w_fetchNonBasic;
  logic [5:0]  w_fetchFirstOp;
  logic        w_irNonBasic;
  logic        w_skipNwA;
  logic        w_skipNwB;
  logic [15:0] w_skipStep;

  // Non-basic words carry their only operand in the b field, so that field
  // is the first one issued to the operand bus.
  assign w_fetchNonBasic = (f_dti[3:0] == 4'h0);
  assign w_fetchFirstOp  = w_fetchNonBasic ? f_dti[15:10] : f_dti[9:4];
  assign w_irNonBasic    = (r_ir[3:0] == 4'h0);

  // A skipped word still occupies its own slot plus one slot per next-word
  // operand; the a field of a non-basic word is an opcode, not an operand.
  assign w_skipNwA  = !w_fetchNonBasic && isNextWord(f_dti[9:4]);
  assign w_skipNwB  = isNextWord(f_dti[15:10]);
  assign w_skipStep = 16'd1 + {15'd0, w_skipNwA} + {15'd0, w_skipNwB};

  // Single sequencer. Every output is a register that is loaded on the
  // transition into the state that presents it, so each state's outputs are
  // valid for its whole cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FE;
      r_pc    <= RST_PC;
      r_ir    <= 16'h0000;
      r_ea    <= 6'h00;
      r_pha   <= 1'b0;
      r_ena   <= 1'b0;
      r_exe   <= 1'b0;
      r_stb   <= 1'b0;
    end else begin
      unique case (r_state)
        FE: begin
          // The strobe is raised here after reset or a skip; an ack seen
          // while the strobe is still low belongs to no request.
          if (!r_stb) begin
            r_stb <= 1'b1;
          end else if (f_ack) begin
            r_stb   <= 1'b0;
            r_ir    <= f_dti;
            r_pc    <= r_pc + 16'd1;
            r_state <= LA;
            r_ena   <= 1'b1;
            r_pha   <= 1'b1;
            r_ea    <= w_fetchFirstOp;
          end
        end
        LA: begin
          if (isNextWord(r_ea)) begin
            r_pc <= r_pc + 16'd1;
          end
          r_ena <= 1'b1;
          if (w_irNonBasic) begin
            r_state <= LC;
            r_pha   <= 1'b0;
            r_ea    <= 6'h20;
          end else begin
            r_state <= LB;
            r_pha   <= 1'b0;
            r_ea    <= r_ir[15:10];
          end
        end
        LB: begin
          if (isNextWord(r_ea)) begin
            r_pc <= r_pc + 16'd1;
          end
          r_state <= LC;
          r_ena   <= 1'b1;
          r_pha   <= 1'b1;
          r_ea    <= 6'h20;
        end
        LC: begin
          r_state <= EX;
          r_ena   <= 1'b0;
          r_exe   <= 1'b1;
        end
        EX: begin
          // PC write wins over skip; both paths start fetching immediately.
          r_exe <= 1'b0;
          r_stb <= 1'b1;
          if (pc_wre) begin
            r_pc    <= pc_dti;
            r_state <= FE;
          end else if (skp) begin
            r_state <= SK;
          end else begin
            r_state <= FE;
          end
        end
        SK: begin
          if (f_ack) begin
            r_stb   <= 1'b0;
            r_pc    <= r_pc + w_skipStep;
            r_state <= FE;
          end
        end
        default: begin
          r_state <= FE;
          r_stb   <= 1'b0;
          r_ena   <= 1'b0;
          r_exe   <= 1'b0;
        end
      endcase
    end
  end

  assign f_adr = r_pc;
  assign f_stb = r_stb;
  assign f_ena = r_stb;
  assign f_wre = 1'b0;
  assign regPC = r_pc;
  assign ir    = r_ir;
  assign ea    = r_ea;
  assign pha   = r_pha;
  assign ena   = r_ena;
  assign exe   = r_exe;

endmodule
